// File: rtl/xy_arb_pkg.sv
// Shared types and constants for the x/y evaluation arbiter: FSM state encoding,
// default parameter values and the modulo-increment helper used by the picker.
package xy_arb_pkg;

    localparam int unsigned NumReqDef     = 4;
    localparam int unsigned DpLatencyDef  = 1;
    localparam int unsigned InitCyclesDef = 2;
    localparam int unsigned CntWDef       = 16;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

// File: rtl/xy_rr_pick.sv
// Combinational round-robin picker: the search starts one past last_grant and wraps,
// returning the first asserted request as a one-hot grant plus its index.
module xy_rr_pick
    import xy_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDef,
    parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IdxW-1:0]    idx,
    output logic               any
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = mod_inc(32'(last_grant), NUM_REQ);
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!any && req[IdxW'(cand)]) begin
                any              = 1'b1;
                gnt[IdxW'(cand)] = 1'b1;
                idx              = IdxW'(cand);
            end
            cand = mod_inc(cand, NUM_REQ);
        end
    end

endmodule

// File: rtl/xy_eval_arbiter.sv
// Round-robin scheduler sharing one x/y evaluation datapath among NUM_REQ requesters.
// Optional per-requester grant counters are built when XY_ARB_STATS_EN is defined.
module xy_eval_arbiter
    import xy_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NumReqDef,
    parameter int unsigned DP_LATENCY  = DpLatencyDef,
    parameter int unsigned INIT_CYCLES = InitCyclesDef,
    parameter int unsigned CNT_W       = CntWDef
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_x,
    input  logic [NUM_REQ-1:0] req_y,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic               rsp_z,
    output logic               dp_clr,
    output logic               dp_valid,
    output logic               dp_x,
    output logic               dp_y,
    input  logic               dp_z,
    output logic               busy
`ifdef XY_ARB_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned TmrMax = (INIT_CYCLES > DP_LATENCY) ? INIT_CYCLES : DP_LATENCY;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    arb_state_e        state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic              op_x_q, op_x_d;
    logic              op_y_q, op_y_d;
    logic              rsp_z_q, rsp_z_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_any;
    logic               handshake;

    xy_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (pick_gnt),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Ready is the picker's grant, so any winner in IDLE is an accepted handshake.
    assign handshake = (state_q == StIdle) && pick_any;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        last_d    = last_q;
        op_x_d    = op_x_q;
        op_y_d    = op_y_q;
        rsp_z_d   = rsp_z_q;
        req_ready = '0;
        rsp_valid = '0;
        dp_clr    = 1'b0;
        dp_valid  = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            StInit: begin
                dp_clr = 1'b1;
                if (tmr_q == TmrW'(1)) begin
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StIdle: begin
                busy      = 1'b0;
                req_ready = pick_gnt;
                if (handshake) begin
                    op_x_d  = req_x[pick_idx];
                    op_y_d  = req_y[pick_idx];
                    last_d  = pick_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                dp_valid = 1'b1;
                tmr_d    = TmrW'(DP_LATENCY);
                state_d  = StWait;
            end
            StWait: begin
                if (tmr_q == TmrW'(1)) begin
                    rsp_z_d = dp_z;
                    state_d = StResp;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StResp: begin
                rsp_valid[last_q] = 1'b1;
                state_d           = StIdle;
            end
            default: begin
                state_d = StInit;
                tmr_d   = TmrW'(INIT_CYCLES);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            tmr_q   <= TmrW'(INIT_CYCLES);
            last_q  <= IdxW'(NUM_REQ - 1);
            op_x_q  <= 1'b0;
            op_y_q  <= 1'b0;
            rsp_z_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            last_q  <= last_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
            rsp_z_q <= rsp_z_d;
        end
    end

    assign dp_x  = op_x_q;
    assign dp_y  = op_y_q;
    assign rsp_z = rsp_z_q;

`ifdef XY_ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0] gcnt_q, gcnt_d;

    // Clear wins over a coincident grant; counts stick at all-ones.
    always_comb begin
        gcnt_d = gcnt_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (stat_clr) begin
                gcnt_d[i*CNT_W +: CNT_W] = '0;
            end else if (handshake && (pick_idx == IdxW'(i)) &&
                         (gcnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                gcnt_d[i*CNT_W +: CNT_W] = gcnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_xy_eval_arbiter.sv
// Randomized bench for xy_eval_arbiter: a transaction-level reference model predicts
// grants and responses; a separate monitor pops a scoreboard whenever rsp_valid fires.
module tb_xy_eval_arbiter;

    localparam int N    = 4;
    localparam int LAT  = 3;
    localparam int INIT = 2;
    localparam int NCYC = 900;
`ifdef XY_ARB_STATS_EN
    localparam int CW   = 3;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid, req_x, req_y, req_ready, rsp_valid;
    logic         rsp_z, dp_clr, dp_valid, dp_x, dp_y, dp_z, busy;
`ifdef XY_ARB_STATS_EN
    logic              stat_clr;
    logic [N*CW-1:0]   grant_cnt;
`endif

    xy_eval_arbiter #(
        .NUM_REQ     (N),
        .DP_LATENCY  (LAT),
`ifdef XY_ARB_STATS_EN
        .CNT_W       (CW),
`endif
        .INIT_CYCLES (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_z     (rsp_z),
        .dp_clr    (dp_clr),
        .dp_valid  (dp_valid),
        .dp_x      (dp_x),
        .dp_y      (dp_y),
        .dp_z      (dp_z),
`ifdef XY_ARB_STATS_EN
        .stat_clr  (stat_clr),
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rsp_cyc;
        int idx;
        int z_cyc;
    } exp_t;

    exp_t sb[$];
    bit   zhist[0:4095];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: transaction-level, cycle numbers are absolute.
    int           last_g    = N - 1;
    int           next_free = 0;
    int           hs_cyc    = -100;
    int           init_left = INIT;
    int           rst_count = 0;
    bit           ox        = 1'b0;
    bit           oy        = 1'b0;
`ifdef XY_ARB_STATS_EN
    int           gcnt[N];
`endif

    initial begin
        int           c;
        int           win;
        int           exp_rdy;
        bit           do_rst;
        bit           idle;
        logic [N-1:0] rv, x, y;
        logic         z;
`ifdef XY_ARB_STATS_EN
        bit           sc;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        stat_clr = 1'b0;
`endif
        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        dp_z      = 1'b0;
        repeat (3) @(posedge clk);

        for (int it = 0; it < NCYC; it++) begin
            @(negedge clk);
            c = cyc;
            if (it == 0) next_free = c + INIT;

            if (it < 60) rv = N'(4);
            else if (it < 160) rv = '1;
            else rv = N'($urandom());
            x = N'($urandom());
            y = N'($urandom());
            z = 1'($urandom_range(0, 1));
            do_rst = (it >= 160) && (c >= hs_cyc + 2) && (c <= hs_cyc + 1 + LAT) &&
                     (($urandom_range(0, 15) == 0) || (rst_count == 0 && it > 400));
`ifdef XY_ARB_STATS_EN
            sc = ($urandom_range(0, 9) == 0);
            stat_clr = sc;
`endif
            reset     = do_rst;
            req_valid = rv;
            req_x     = x;
            req_y     = y;
            dp_z      = z;
            zhist[c]  = z;
            #1;

            idle = (c >= next_free);
            win  = -1;
            if (idle) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && rv[(last_g + k) % N]) win = (last_g + k) % N;
                end
            end
            exp_rdy = (win >= 0) ? (1 << win) : 0;

            check("req_ready", int'(req_ready), exp_rdy);
            check("busy", int'(busy), int'(!idle));
            check("dp_clr", int'(dp_clr), int'(init_left > 0));
            check("dp_valid", int'(dp_valid), int'(c == hs_cyc + 1));
            check("dp_x", int'(dp_x), int'(ox));
            check("dp_y", int'(dp_y), int'(oy));
`ifdef XY_ARB_STATS_EN
            for (int i = 0; i < N; i++) check("grant_cnt", int'(grant_cnt[i*CW +: CW]), gcnt[i]);
`endif

            if (init_left > 0) init_left--;
            if (do_rst) begin
                while (sb.size() > 0 && sb[$].rsp_cyc > c) void'(sb.pop_back());
                last_g    = N - 1;
                next_free = c + 1 + INIT;
                init_left = INIT;
                hs_cyc    = -100;
                ox        = 1'b0;
                oy        = 1'b0;
                rst_count++;
`ifdef XY_ARB_STATS_EN
                for (int i = 0; i < N; i++) gcnt[i] = 0;
`endif
            end else begin
`ifdef XY_ARB_STATS_EN
                for (int i = 0; i < N; i++) begin
                    if (sc) gcnt[i] = 0;
                    else if (win == i && gcnt[i] < (1 << CW) - 1) gcnt[i]++;
                end
`endif
                if (win >= 0) begin
                    sb.push_back('{rsp_cyc: c + 2 + LAT, idx: win, z_cyc: c + 1 + LAT});
                    last_g    = win;
                    next_free = c + 3 + LAT;
                    hs_cyc    = c;
                    ox        = x[win];
                    oy        = y[win];
                end
            end
        end

        @(negedge clk);
        req_valid = '0;
        reset     = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Monitor: decoupled from stimulus, consumes one expected response per rsp pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", int'(rsp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_cycle", cyc, e.rsp_cyc);
                    check("rsp_valid", int'(rsp_valid), 1 << e.idx);
                    check("rsp_z", int'(rsp_z), int'(zhist[e.z_cyc]));
                end
            end else if (sb.size() > 0 && sb[0].rsp_cyc <= cyc) begin
                e = sb.pop_front();
                check("rsp_missing", int'(rsp_valid), 1 << e.idx);
            end
        end
    end

endmodule

// File: doc/xy_eval_arbiter.md
# xy_eval_arbiter

Round-robin scheduler that shares one x/y evaluation datapath (the combinational-plus-stateful x/y→z unit) among NUM_REQ requesters. It drives the datapath's clear at start-up, accepts one request at a time over a valid/ready handshake, and issues that request's operands to the datapath. It samples the datapath result after a fixed latency and returns it to the winning requester as a one-cycle response pulse. It sits between the requester ports and the single shared datapath instance.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DP_LATENCY, 1, cycles from dp_valid to dp_z valid (≥1)
- INIT_CYCLES, 2, cycles dp_clr is held after reset (≥1)
- CNT_W, 16, grant counter width (stats only)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_x  in  NUM_REQ  per-requester x operand
- req_y  in  NUM_REQ  per-requester y operand
- req_ready  out  NUM_REQ  one-hot accept (combinational, IDLE only)
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
- rsp_z  out  1  result; qualified by rsp_valid
- dp_clr  out  1  datapath synchronous clear
- dp_valid  out  1  operand issue strobe
- dp_x  out  1  datapath x
- dp_y  out  1  datapath y
- dp_z  in  1  datapath result
- busy  out  1  high in any state other than IDLE
- stat_clr  in  1  clears grant counters (STATS only)
- grant_cnt  out  NUM_REQ*CNT_W  per-requester grant counts, requester i at bits [i*CNT_W +: CNT_W] (STATS only)

## Operation
- States: INIT, IDLE, ISSUE, WAIT, RESP.
- INIT: dp_clr=1 and req_ready=0 for INIT_CYCLES cycles, then IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready = one-hot winner, or 0 if no request.
  - On handshake: capture req_x/req_y of winner into operand register, last_grant ← winner, go to ISSUE.
- ISSUE: dp_valid=1 for exactly one cycle; load wait counter with DP_LATENCY; go to WAIT.
- WAIT: decrement counter each cycle. On the cycle the counter reads 1, register dp_z into rsp_z and go to RESP.
- RESP: rsp_valid[last_grant]=1 for one cycle; rsp_z held until the next RESP; go to IDLE.
- dp_x/dp_y are driven from the operand register at all times (0 after reset) and are stable from ISSUE through WAIT.
- Responses have no backpressure. A requester must accept rsp in the RESP cycle.
- Requesters not granted keep req_valid asserted. Withdrawing req_valid before the handshake is legal.

## Timing
- Reset values:
  - state=INIT, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - Operand register 0, rsp_z=0, rsp_valid=0, dp_valid=0, dp_clr=1 (first INIT cycle), busy=1.
- Handshake cycle T (IDLE): ISSUE at T+1; dp_z sampled at end of T+1+DP_LATENCY; rsp_valid at T+2+DP_LATENCY.
- Next accept is possible at T+3+DP_LATENCY, giving one transaction per DP_LATENCY+3 cycles.
- Reset asserted in any state:
  - Next cycle is INIT and the in-flight transaction is dropped (no rsp_valid).
  - dp_clr is re-asserted for the full INIT_CYCLES.
- Single requester re-requesting continuously is granted every transaction. With all requesters valid, grants rotate 0,1,…,NUM_REQ-1,0.
- Pointer wrap: after last_grant=NUM_REQ-1, search starts at 0.

## Configuration
- XY_ARB_STATS_EN defined:
  - stat_clr and grant_cnt exist.
  - grant_cnt[i] increments on each handshake of requester i and saturates at all-ones.
  - stat_clr and reset zero all counters; stat_clr has priority over increment.
- XY_ARB_STATS_EN not defined: both ports and all counter logic are absent. Scheduling behaviour is identical.

## Structure
- Package xy_arb_pkg:
  - State enum typedef (INIT, IDLE, ISSUE, WAIT, RESP).
  - Default parameter constants.
  - Function for mod-NUM_REQ increment.
- Sub-module xy_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, index, any.

## Test plan
- Reset, then idle: dp_clr=1 for exactly 2 cycles, req_ready=0 during INIT, busy falls at cycle 3.
- Single request, req 2, x=1, y=0, DP_LATENCY=1, dp_z tied to model: handshake at T, dp_valid at T+1, rsp_valid=4'b0100 with rsp_z=1 at T+3.
- All four valid continuously: grant order 0,1,2,3,0; each rsp_valid one-hot matches that order; accepts spaced 4 cycles apart.
- Reset asserted during WAIT: no rsp_valid, INIT re-entered, then requester 0 has first priority.
- DP_LATENCY=3, dp_z toggled each cycle: rsp_z equals the dp_z value at ISSUE+3.
- STATS build: 5 grants to req 1 → grant_cnt[1]=5. stat_clr coincident with a grant → 0. CNT_W=2 with 5 grants → saturates at 3.
